// File: rtl/mac_operand_loader.sv
// Wishbone-slave operand loader for the mac unit: stages eight operand words,
// launches them as a 256-bit vector and captures the result after a fixed latency.
module mac_operand_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WORDS     = 8,
    parameter int          RES_W     = 28,
    parameter int          MAC_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [WORDS*32-1:0]   mac_data_in,
    input  logic [RES_W-1:0]      mac_data_out,
    output logic                  busy,
    output logic                  done_irq
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [3:0] LAT_LAST = 4'(MAC_LAT - 1);

    logic [31:0]         stage_q [WORDS];
    logic [31:0]         stage_d [WORDS];
    logic [WORDS*32-1:0] active_q, active_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [3:0]          lat_q, lat_d;
    logic [0:0]          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;

    logic        hit_s, req_s, wr_s, rd_s, ctrl_wr_s, start_s, clr_s, complete_s;
    logic [2:0]  widx_s;
    logic [31:0] rdata_s;
    logic        unused_adr_s;

    assign hit_s        = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign req_s        = wbs_stb_i & wbs_cyc_i & hit_s & ~ack_q;
    assign wr_s         = req_s & wbs_we_i;
    assign rd_s         = req_s & ~wbs_we_i;
    assign widx_s       = wbs_adr_i[4:2];
    assign ctrl_wr_s    = wr_s & (wbs_adr_i[5:2] == 4'h8);
    assign start_s      = ctrl_wr_s & wbs_dat_i[0];
    assign clr_s        = ctrl_wr_s & wbs_dat_i[1];
    assign complete_s   = (state_q == ST_RUN) && (lat_q == LAT_LAST);
    assign unused_adr_s = ^wbs_adr_i[1:0];

    // Byte-masked staging writes; unselected bytes and other words hold.
    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            for (int b = 0; b < 4; b++) begin
                stage_d[k][b*8 +: 8] = (wr_s && !wbs_adr_i[5] && (widx_s == 3'(k)) && wbs_sel_i[b])
                                       ? wbs_dat_i[b*8 +: 8] : stage_q[k][b*8 +: 8];
            end
        end
    end

    // Read data multiplexer over the register map.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!wbs_adr_i[5]) begin
            rdata_s = stage_q[widx_s];
        end else begin
            case (wbs_adr_i[4:2])
                3'd1:    rdata_s = {29'd0, overrun_q, done_q, busy_q};
                3'd2:    rdata_s = 32'(result_q);
                3'd3:    rdata_s = {16'd0, cnt_q};
                default: rdata_s = 32'h0000_0000;
            endcase
        end
    end

    // Single-cycle acknowledge with registered read data.
    always_comb begin
        ack_d = req_s;
        if (rd_s) begin
            dat_d = rdata_s;
        end else if (req_s) begin
            dat_d = 32'h0000_0000;
        end else begin
            dat_d = dat_q;
        end
    end

    // Operation sequencer: launch, latency count, result capture, flags.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        busy_d    = busy_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        lat_d     = lat_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_RUN;
                    for (int k = 0; k < WORDS; k++) begin
                        active_d[k*32 +: 32] = stage_q[k];
                    end
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    lat_d     = 4'd0;
                    overrun_d = clr_s ? 1'b0 : overrun_q;
                end else if (clr_s) begin
                    done_d    = 1'b0;
                    overrun_d = 1'b0;
                end else begin
                    done_d    = done_q;
                end
            end
            ST_RUN: begin
                lat_d = lat_q + 4'd1;
                // A clear in the same write beats the overrun it would otherwise flag.
                if (clr_s) begin
                    overrun_d = 1'b0;
                end else if (start_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (complete_s) begin
                    result_d = mac_data_out;
                    cnt_d    = cnt_q + 16'd1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < WORDS; k++) begin
                stage_q[k] <= 32'h0000_0000;
            end
            active_q  <= '0;
            result_q  <= '0;
            cnt_q     <= 16'd0;
            lat_q     <= 4'd0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'h0000_0000;
        end else begin
            for (int k = 0; k < WORDS; k++) begin
                stage_q[k] <= stage_d[k];
            end
            active_q  <= active_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign mac_data_in = active_q;
    assign busy        = busy_q;
    assign done_irq    = done_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader with a one-stage mac model and a
// scoreboard queue of expected results pushed at each launch.
module tb_mac_operand_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h20;
    localparam logic [31:0] A_STAT = BASE + 32'h24;
    localparam logic [31:0] A_RES  = BASE + 32'h28;
    localparam logic [31:0] A_CNT  = BASE + 32'h2C;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = 4'h0;
    logic [31:0]  wbs_dat_i = 32'h0, wbs_adr_i = 32'h0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [255:0] mac_data_in;
    logic [27:0]  mac_data_out;
    logic         busy, done_irq;

    logic [27:0]  mac_pipe = 28'h0;
    logic [31:0]  stg [8];
    logic [27:0]  sb [$];
    logic [255:0] exp_vec;
    logic [15:0]  cnt_exp;
    int           n_pass = 0, n_total = 0;

    mac_operand_loader dut (
        .clk(clk), .reset_n(reset_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .mac_data_in(mac_data_in), .mac_data_out(mac_data_out),
        .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] mac_f(input logic [255:0] v);
        logic [31:0] x;
        x = 32'h0;
        for (int k = 0; k < 8; k++) x = x ^ v[k*32 +: 32];
        return x[27:0] ^ 28'h8234567;
    endfunction

    // Mac model: result of the current operand vector is valid one edge later.
    always @(posedge clk) mac_pipe <= mac_f(mac_data_in);
    assign mac_data_out = mac_pipe;

    function automatic logic [255:0] stg_vec();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = stg[k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
        @(negedge clk);
        chk("ack_idle_w", wbs_ack_o, 1'b0);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr; wbs_dat_i = d; wbs_sel_i = sel;
        @(negedge clk);
        chk("ack_w", wbs_ack_o, 1'b1);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        if (adr[31:6] == BASE[31:6] && !adr[5]) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) stg[adr[4:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        chk("ack_idle_r", wbs_ack_o, 1'b0);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
        @(negedge clk);
        chk("ack_r", wbs_ack_o, 1'b1);
        chk(tag, wbs_dat_o, exp);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done_irq; i++) @(negedge clk);
        chk("done_wait", done_irq, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) stg[k] = 32'h0;
        cnt_exp = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mac_in", mac_data_in, 256'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done_irq, 1'b0);
        chk("rst_ack", wbs_ack_o, 1'b0);
        reset_n = 1'b1;
        wb_read(A_STAT, 32'h0, "rst_status");
        wb_read(A_RES, 32'h0, "rst_result");
        wb_read(A_CNT, 32'h0, "rst_count");
        wb_read(A_CTRL, 32'h0, "ctrl_reads0");
        wb_read(BASE + 32'h30, 32'h0, "rsvd30");
        wb_read(BASE + 32'h3C, 32'h0, "rsvd3c");
        for (int k = 0; k < 8; k++) wb_read(BASE + 32'(4*k), 32'h0, "rst_word");

        // Base mismatch is never acked
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_adr_i = 32'h4000_0000;
        repeat (3) begin
            @(negedge clk);
            chk("miss_noack", wbs_ack_o, 1'b0);
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;

        // Byte selects, read-only write ignored
        wb_write(BASE, 32'h0403_0201, 4'b0101);
        wb_read(BASE, 32'h0003_0001, "word0_sel");
        chk("mac_in_no_start", mac_data_in[31:0], 32'h0);
        wb_write(A_RES, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_RES, 32'h0, "result_ro");

        // Full load and single operation
        for (int k = 0; k < 8; k++) wb_write(BASE + 32'(4*k), 32'h1111_1111 * 32'(k + 1), 4'hF);
        sb.push_back(mac_f(stg_vec()));
        exp_vec = stg_vec();
        wb_write(A_CTRL, 32'h1, 4'hF);
        chk("busy_e0", busy, 1'b1);
        chk("mac_in_load", mac_data_in, exp_vec);
        @(negedge clk);
        chk("busy_e1", busy, 1'b1);
        chk("done_e1", done_irq, 1'b0);
        @(negedge clk);
        chk("busy_e2", busy, 1'b0);
        chk("done_e2", done_irq, 1'b1);
        cnt_exp++;
        wb_read(A_RES, 32'(sb.pop_front()), "result1");
        wb_read(A_STAT, 32'h2, "status_done");
        wb_read(A_CNT, {16'd0, cnt_exp}, "count1");

        // Start while running: overrun, original completion
        wb_write(BASE + 32'h4, 32'hCAFE_F00D, 4'hF);
        sb.push_back(mac_f(stg_vec()));
        exp_vec = stg_vec();
        wb_write(A_CTRL, 32'h1, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        chk("ovr_done", done_irq, 1'b1);
        chk("ovr_busy", busy, 1'b0);
        chk("ovr_mac_in", mac_data_in, exp_vec);
        wb_write(BASE + 32'h8, 32'h55AA_55AA, 4'hF);
        chk("stage_no_disturb", mac_data_in, exp_vec);
        cnt_exp++;
        wb_read(A_STAT, 32'h6, "status_ovr");
        wb_read(A_RES, 32'(sb.pop_front()), "result2");
        wb_write(A_CTRL, 32'h2, 4'hF);
        wb_read(A_STAT, 32'h0, "status_clr");

        // Start+clear while done is set
        sb.push_back(mac_f(stg_vec()));
        wb_write(A_CTRL, 32'h1, 4'hF);
        wait_done();
        cnt_exp++;
        wb_read(A_RES, 32'(sb.pop_front()), "result3");
        wb_write(BASE + 32'h14, 32'h0F0F_1234, 4'hF);
        sb.push_back(mac_f(stg_vec()));
        wb_write(A_CTRL, 32'h3, 4'hF);
        chk("c3_done_low", done_irq, 1'b0);
        chk("c3_busy", busy, 1'b1);
        wb_read(A_STAT, 32'h1, "c3_status_busy");
        cnt_exp++;
        wb_read(A_STAT, 32'h2, "c3_status_done");
        wb_read(A_RES, 32'(sb.pop_front()), "result4");
        wb_read(A_CNT, {16'd0, cnt_exp}, "count4");

        // Reset one cycle into RUN
        wb_write(BASE + 32'h18, 32'h7777_0001, 4'hF);
        sb.push_back(mac_f(stg_vec()));
        wb_write(A_CTRL, 32'h1, 4'hF);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done_irq, 1'b0);
        chk("arst_mac_in", mac_data_in, 256'd0);
        void'(sb.pop_front());
        for (int k = 0; k < 8; k++) stg[k] = 32'h0;
        cnt_exp = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wb_read(A_RES, 32'h0, "arst_result");
        wb_read(A_CNT, 32'h0, "arst_count");
        wb_read(A_STAT, 32'h0, "arst_status");
        wb_read(BASE + 32'h18, 32'h0, "arst_word6");

        // COUNT wrap
        wb_write(BASE + 32'hC, 32'h1234_5678, 4'hF);
        force dut.cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        cnt_exp = 16'hFFFF;
        wb_read(A_CNT, {16'd0, cnt_exp}, "count_preset");
        sb.push_back(mac_f(stg_vec()));
        wb_write(A_CTRL, 32'h1, 4'hF);
        wait_done();
        cnt_exp = cnt_exp + 16'd1;
        wb_read(A_RES, 32'(sb.pop_front()), "result_wrap");
        wb_read(A_CNT, {16'd0, cnt_exp}, "count_wrap");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
